// File: rtl/sound_lut_player_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_lut_player_if : control, LUT read port and sample output bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface sound_lut_player_if #(
  parameter int LUT_AW = 11,
  parameter int LUT_DW = 32
) ();
  logic              trigger;
  logic              freq_wr;
  logic [LUT_AW-1:0] freq;
  logic [1:0]        duty;
  logic [3:0]        volume;
  logic              length_en;
  logic [5:0]        length;
  logic              tick_256;
  logic [LUT_AW-1:0] lut_addr;
  logic [LUT_DW-1:0] lut_dout;
  logic [3:0]        sample;
  logic              sample_valid;
  logic              active;

  modport master (
    output trigger, freq_wr, freq, duty, volume, length_en, length, tick_256, lut_dout,
    input  lut_addr, sample, sample_valid, active
  );

  modport slave (
    input  trigger, freq_wr, freq, duty, volume, length_en, length, tick_256, lut_dout,
    output lut_addr, sample, sample_valid, active
  );
endinterface
`default_nettype wire

// File: rtl/sound_lut_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_lut_player : duty-cycle pulse channel timed by periods read from a LUT BRAM
// Revision 1.0
// ---------------------------------------------------------------------------
module sound_lut_player #(
  parameter int LUT_AW = 11,
  parameter int LUT_DW = 32
) (
  input wire logic           clka,
  input wire logic           rsta,
  sound_lut_player_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam logic [LUT_DW-1:0] c_one = {{(LUT_DW-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [LUT_AW-1:0] r_lut_addr;
  logic [3:0]        r_sample;
  logic              r_sample_valid;
  logic              r_active;
  logic [2:0]        r_phase;
  logic [LUT_DW-1:0] r_period;
  logic [LUT_DW-1:0] r_pcnt;
  logic [6:0]        r_lcnt;

  logic [7:0]        w_pattern;
  logic [2:0]        w_phase_nx;
  logic [LUT_DW-1:0] w_period_ld;
  logic              w_len_dec;

  always_comb begin
    w_pattern = 8'h01;
    case (bus.duty)
      2'd0:    w_pattern = 8'h01;
      2'd1:    w_pattern = 8'h81;
      2'd2:    w_pattern = 8'h87;
      default: w_pattern = 8'h7E;
    endcase
  end

  assign w_phase_nx  = r_phase + 3'd1;
  // A zero LUT entry would stall the counter; treat it as one cycle per step
  assign w_period_ld = (bus.lut_dout == '0) ? c_one : bus.lut_dout;
  assign w_len_dec   = bus.tick_256 && bus.length_en && r_active && (r_lcnt != 7'd0);

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      r_state        <= S_IDLE;
      r_lut_addr     <= '0;
      r_sample       <= 4'd0;
      r_sample_valid <= 1'b0;
      r_active       <= 1'b0;
      r_phase        <= 3'd0;
      r_period       <= '0;
      r_pcnt         <= '0;
      r_lcnt         <= 7'd0;
    end else begin
      r_sample_valid <= 1'b0;
      if (bus.trigger) begin
        r_lcnt     <= 7'd64 - {1'b0, bus.length};
        r_lut_addr <= bus.freq;
        r_phase    <= 3'd0;
        r_state    <= S_ADDR;
      end else if (r_active && (r_lcnt == 7'd0)) begin
        r_state  <= S_IDLE;
        r_active <= 1'b0;
        r_sample <= 4'd0;
      end else begin
        if (w_len_dec) begin
          r_lcnt <= r_lcnt - 7'd1;
        end
        case (r_state)
          S_IDLE: begin
            r_sample <= 4'd0;
            r_active <= 1'b0;
          end
          S_ADDR: r_state <= S_WAIT;
          S_WAIT: begin
            r_period <= w_period_ld;
            r_pcnt   <= w_period_ld;
            r_active <= 1'b1;
            r_state  <= S_RUN;
          end
          S_RUN: begin
            if (bus.freq_wr) begin
              r_lut_addr <= bus.freq;
              r_state    <= S_ADDR;
            end else if (r_pcnt == c_one) begin
              r_pcnt         <= r_period;
              r_phase        <= w_phase_nx;
              r_sample       <= w_pattern[w_phase_nx] ? bus.volume : 4'd0;
              r_sample_valid <= 1'b1;
            end else begin
              r_pcnt <= r_pcnt - c_one;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.lut_addr     = r_lut_addr;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.active       = r_active;

endmodule
`default_nettype wire

// File: tb/tb_sound_lut_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sound_lut_player : directed and random stimulus against a timeline model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_sound_lut_player;

  logic clka = 1'b0;
  logic rsta = 1'b1;
  always #5 clka = ~clka;

  sound_lut_player_if #(.LUT_AW(11), .LUT_DW(32)) bus ();

  sound_lut_player #(.LUT_AW(11), .LUT_DW(32)) dut (
    .clka (clka),
    .rsta (rsta),
    .bus  (bus)
  );

  logic [31:0] mem [0:2047];
  always @(posedge clka) bus.lut_dout <= mem[bus.lut_addr];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: edge-numbered timeline of fetch completion and phase advances
  logic [7:0]  pat [4];
  longint      cyc = 0;
  bit          m_fetching, m_running, m_active, m_sv;
  longint      m_fetch_at, m_next, m_per;
  int          m_phase, m_lcnt;
  logic [10:0] m_addr;
  logic [3:0]  m_sample;

  task automatic model_step();
    logic [7:0] p;
    cyc++;
    m_sv = 1'b0;
    if (rsta) begin
      m_fetching = 0; m_running = 0; m_active = 0; m_phase = 0; m_lcnt = 0;
      m_addr = '0; m_sample = '0; m_per = 0;
    end else if (bus.trigger) begin
      m_lcnt = 64 - int'(bus.length);
      m_addr = bus.freq;
      m_phase = 0;
      m_fetching = 1; m_fetch_at = cyc + 2; m_running = 0;
    end else if (m_active && m_lcnt == 0) begin
      m_fetching = 0; m_running = 0; m_active = 0; m_sample = 0;
    end else begin
      if (bus.tick_256 && bus.length_en && m_active && m_lcnt > 0) m_lcnt--;
      if (m_fetching) begin
        if (cyc == m_fetch_at) begin
          m_per = (mem[m_addr] == 0) ? 1 : longint'(mem[m_addr]);
          m_next = cyc + m_per;
          m_active = 1; m_running = 1; m_fetching = 0;
        end
      end else if (m_running) begin
        if (bus.freq_wr) begin
          m_addr = bus.freq;
          m_fetching = 1; m_fetch_at = cyc + 2; m_running = 0;
        end else if (cyc == m_next) begin
          m_phase = (m_phase + 1) % 8;
          p = pat[bus.duty];
          m_sample = p[m_phase] ? bus.volume : 4'd0;
          m_sv = 1'b1;
          m_next = m_next + m_per;
        end
      end else begin
        m_sample = 0; m_active = 0;
      end
    end
  endtask

  always @(posedge clka or posedge rsta) model_step();

  always @(negedge clka) begin
    chk("lut_addr", 32'(bus.lut_addr), 32'(m_addr));
    chk("sample", 32'(bus.sample), 32'(m_sample));
    chk("sample_valid", 32'(bus.sample_valid), 32'(m_sv));
    chk("active", 32'(bus.active), 32'(m_active));
  end

  task automatic step(input bit trg, input bit fw, input bit tk);
    @(negedge clka);
    bus.trigger  = trg;
    bus.freq_wr  = fw;
    bus.tick_256 = tk;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  initial begin
    pat[0] = 8'h01; pat[1] = 8'h81; pat[2] = 8'h87; pat[3] = 8'h7E;
    for (int i = 0; i < 2048; i++) mem[i] = 32'($urandom_range(1, 6));
    mem[11'h100] = 32'd5;
    mem[11'h7FF] = 32'd0;
    mem[11'h200] = 32'd3;
    mem[11'h300] = 32'd0;
    bus.trigger = 0; bus.freq_wr = 0; bus.tick_256 = 0; bus.freq = '0;
    bus.duty = 2'd2; bus.volume = 4'hF; bus.length_en = 0; bus.length = '0;

    // reset state
    repeat (3) @(negedge clka);
    chk("rst_addr", 32'(bus.lut_addr), 32'd0);
    chk("rst_sample", 32'(bus.sample), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    rsta = 1'b0;
    idle(3);

    // period 5, 50% duty: trigger-to-active latency and sample sequence
    bus.freq = 11'h100;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("t2_addr", 32'(bus.lut_addr), 32'h100);
    chk("t2_act_e1", 32'(bus.active), 32'd0);
    step(0, 0, 0);
    chk("t2_act_e2", 32'(bus.active), 32'd0);
    step(0, 0, 0);
    chk("t2_act_e3", 32'(bus.active), 32'd1);
    idle(5);
    chk("t2_first_sv", 32'(bus.sample_valid), 32'd1);
    chk("t2_first_smp", 32'(bus.sample), 32'hF);
    idle(60);

    // asynchronous reset between edges while running
    #2 rsta = 1'b1;
    #1;
    chk("t1_sample", 32'(bus.sample), 32'd0);
    chk("t1_sv", 32'(bus.sample_valid), 32'd0);
    chk("t1_active", 32'(bus.active), 32'd0);
    chk("t1_addr", 32'(bus.lut_addr), 32'd0);
    @(negedge clka);
    rsta = 1'b0;
    idle(12);

    // zero LUT entry clamps to one cycle per phase step
    bus.freq = 11'h7FF; bus.duty = 2'd3; bus.volume = 4'h9;
    step(1, 0, 0);
    idle(25);
    chk("t3_sv_each", 32'(bus.sample_valid), 32'd1);

    // length counter expiry: 64-60 = 4 ticks
    bus.freq = 11'h100; bus.duty = 2'd1; bus.length = 6'd60; bus.length_en = 1;
    step(1, 0, 0);
    idle(4);
    for (int t = 0; t < 4; t++) begin
      step(0, 0, 1);
      idle(3);
    end
    chk("t4_off_active", 32'(bus.active), 32'd0);
    chk("t4_off_sample", 32'(bus.sample), 32'd0);
    bus.length_en = 0;
    step(1, 0, 0);
    idle(4);
    for (int t = 0; t < 10; t++) begin
      step(0, 0, 1);
      idle(2);
    end
    chk("t4_frozen_active", 32'(bus.active), 32'd1);

    // frequency rewrite at phase 4 keeps phase and length state
    bus.freq = 11'h100; bus.duty = 2'd2;
    step(1, 0, 0);
    begin
      int guard = 0;
      while (!(m_running && m_phase == 4) && guard < 200) begin
        idle(1);
        guard++;
      end
      chk("t5_reach_phase4", 32'(guard < 200), 32'd1);
    end
    bus.freq = 11'h200;
    step(0, 1, 0);
    idle(2);
    chk("t5_no_sv", 32'(bus.sample_valid), 32'd0);
    chk("t5_active", 32'(bus.active), 32'd1);
    idle(30);

    // trigger beats freq_wr and a coincident tick
    bus.length_en = 1; bus.length = 6'd62; bus.freq = 11'h300;
    step(1, 1, 1);
    idle(8);
    bus.freq = 11'h100;
    step(1, 0, 1);
    idle(6);
    step(0, 0, 1);
    idle(2);
    chk("t6_still_active", 32'(bus.active), 32'd1);
    step(0, 0, 1);
    idle(3);
    chk("t6_expired", 32'(bus.active), 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) bus.duty = 2'($urandom);
      if ($urandom_range(0, 9) == 0) bus.volume = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.length_en = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus.length = 6'($urandom_range(40, 63));
      case ($urandom_range(0, 3))
        0: bus.freq = 11'h100;
        1: bus.freq = 11'h7FF;
        2: bus.freq = 11'h200;
        default: bus.freq = 11'($urandom);
      endcase
      step($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
